uart_rcv: RTL and testbench
===========================

Name: uart_rcv

Overview:
- UART receiver; the consuming stage for the UART transmitter's serial line (8N1, LSB first, idle high).
- Oversamples `rx` using a shared baud-rate-times-OVERSAMPLE clock-enable from the baud generator.
- Validates the start bit, samples each data bit mid-bit and checks the stop bit.
- Presents each byte on a parallel port with a ready flag that the consumer clears.

Parameters:
- OVERSAMPLE, 16, number of `clken` ticks per bit period. Must be even and at least 4.

Ports:
- clk_50m  input  1  system clock; the single clock domain.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line.
- clken  input  1  one-cycle strobe at OVERSAMPLE times the baud rate.
- rdy_clr  input  1  consumer acknowledge; clears `rdy`.
- data  output  8  last correctly framed byte.
- rdy  output  1  new byte available in `data`.
- frame_err  output  1  last frame had a low stop bit.
- overrun  output  1  a byte completed while `rdy` was still 1.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset and all clocked logic are on the clk_50m rising edge with synchronous, active-high `rst`.
- Reset values:
  - Outputs: `data`=8'h00, `rdy`=0, `frame_err`=0, `overrun`=0.
  - Internal: state=IDLE, sample counter=0, bitpos=0, shift register=0.
  - Both synchronizer flops reset to 1.
- Reset mid-frame abandons the frame. The line is not re-examined until the next high-to-low transition seen in IDLE.
- Input path: `rx` passes through a 2-flop synchronizer to give `rx_s`, a 2-cycle latency. Only `rx_s` is used.
- All state and counter updates below happen only on cycles where `clken`=1, except the `rdy_clr` handling.
- Sample counter width is clog2(OVERSAMPLE).
- IDLE:
  - If `rx_s`=0, go to START with sample=0.
- START (start-bit validation):
  - If `rx_s`=1, treat it as a glitch and return to IDLE. No flags change.
  - Else, if sample==OVERSAMPLE/2-1, go to DATA with sample=0 and bitpos=0. This point is the mid-start-bit.
  - Else sample+1.
- DATA:
  - If sample==OVERSAMPLE-1, load `rx_s` into shift[bitpos] (bit 0 is received first) and set sample=0.
    - If bitpos==7, go to STOP; otherwise bitpos+1.
  - Else sample+1.
- STOP:
  - If sample==OVERSAMPLE-1, go to IDLE and set sample=0, then:
    - If `rx_s`=1: `data`<=shift, `rdy`<=1, `frame_err`<=0, and `overrun`<=`rdy`, i.e. 1 if the previous byte was still unacknowledged.
    - If `rx_s`=0: `frame_err`<=1. `data` and `rdy` are unchanged.
  - Else sample+1.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames.
- `rdy_clr` (evaluated every clock, independent of `clken`):
  - Clears `rdy` and `overrun` on the next edge.
  - If it coincides with a successful stop-bit check, the set wins: `rdy`=1, `overrun`=0.
- `frame_err` is sticky until the next successful frame or reset. `rdy_clr` does not clear it.
- `rx_busy` = (state != IDLE), combinational.
- A `clken` pulse longer than one cycle is outside the contract.

Test Plan:
1. **Basic byte.** Reset, then send 0xA5 at 115200 baud (`clken` every 27 clocks, OVERSAMPLE=16).
   - `rdy` rises about 9.5 bit periods after the start edge; `data`=8'hA5, `frame_err`=0, `overrun`=0.
   - Pulse `rdy_clr`; `rdy`=0 on the next edge.
2. **Loopback to the transmitter.** Drive 0x00, 0xFF, 0x55, 0x81 back-to-back.
   - All four received in order; each `rdy` is cleared between bytes; no errors.
3. **Glitch rejection.** Hold `rx` low for 5 `clken` ticks, then high.
   - Receiver returns to IDLE; `rdy`, `data`, `frame_err` unchanged.
   - A following valid 0x3C is received correctly.
4. **Framing error.** Send 0x12 with the stop bit held low.
   - `frame_err`=1, `rdy` stays 0, `data` holds its previous value.
   - A subsequent good 0x34 gives `frame_err`=0, `data`=8'h34, `rdy`=1.
5. **Overrun and simultaneous clear.**
   - Receive 0x11 without acknowledging, then 0x22: `data`=8'h22, `overrun`=1.
   - Assert `rdy_clr` in the same cycle that 0x33 completes: `rdy`=1, `overrun`=0.
6. **Reset mid-frame.** Assert `rst` for one cycle during data bit 4 of 0xF0.
   - All outputs return to reset values and `rx_busy`=0.
   - The remainder of that frame produces no `rdy`; the next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rcv.sv
// uart_rcv: 8N1 UART receiver (LSB first, idle high), oversampled by a shared
// clock-enable strobe running at OVERSAMPLE times the baud rate.
//
// Ports:
//   clk_50m    in   system clock, single clock domain
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line (synchronized internally)
//   clken      in   one-cycle strobe at OVERSAMPLE x baud
//   rdy_clr    in   consumer acknowledge, clears rdy/overrun
//   data       out  last correctly framed byte
//   rdy        out  new byte available on data
//   frame_err  out  last frame had a low stop bit (sticky until next good frame)
//   overrun    out  a byte completed while rdy was still set
//   rx_busy    out  receiver not idle (combinational from state)
module uart_rcv #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Synchronizer and datapath registers
  logic             sync1_q;
  logic             rx_s_q;
  state_e           state_q,  state_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [BIT_W-1:0] bitpos_q, bitpos_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       data_q,   data_d;
  logic             rdy_q,    rdy_d;
  logic             ferr_q,   ferr_d;
  logic             ovr_q,    ovr_d;
  logic             byte_done;

  // Next-state logic: framing FSM advances only on clken; rdy_clr acts every cycle
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    bitpos_d  = bitpos_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    byte_done = 1'b0;

    if (clken) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d  = ST_START;
            sample_d = '0;
          end
        end

        ST_START: begin
          if (rx_s_q) begin
            // Line went back high before mid-start-bit: treat as a glitch
            state_d = ST_IDLE;
          end else if (sample_q == CNT_HALF) begin
            // Mid-start-bit reached; data bits are sampled a full period apart
            state_d  = ST_DATA;
            sample_d = '0;
            bitpos_d = '0;
          end else begin
            sample_d = sample_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (sample_q == CNT_LAST) begin
            shift_d[bitpos_q] = rx_s_q;
            sample_d          = '0;
            if (bitpos_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bitpos_d = bitpos_q + BIT_W'(1);
            end
          end else begin
            sample_d = sample_q + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (sample_q == CNT_LAST) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed
            state_d  = ST_IDLE;
            sample_d = '0;
            if (rx_s_q) begin
              data_d    = shift_q;
              ferr_d    = 1'b0;
              byte_done = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A completing byte wins over a simultaneous acknowledge
    if (byte_done) begin
      rdy_d = 1'b1;
      ovr_d = rdy_q & ~rdy_clr;
    end else if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bitpos_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= rx;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      sample_q <= sample_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rcv.sv
// tb_uart_rcv: directed bench for uart_rcv with a scoreboard. Each frame pushes
// the expected output snapshot; a monitor pops and compares whenever the
// receiver drops back to idle.
module tb_uart_rcv;

  localparam int CLKS_PER_TICK = 27;
  localparam int CLKS_PER_BIT  = 16 * CLKS_PER_TICK;
  localparam int NO_RST        = -1;

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   mon_en;
  bit   auto_ack;
  bit   hold_clr;
  int   tick_cnt;

  uart_rcv #(.OVERSAMPLE(16)) dut (
    .clk_50m  (clk),
    .rst      (rst),
    .rx       (rx),
    .clken    (clken),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // clken: one cycle in every 27 (115200 baud x16 from 50 MHz)
  initial begin
    clken    = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == CLKS_PER_TICK - 1) ? 0 : tick_cnt + 1;
      clken    = (tick_cnt == CLKS_PER_TICK - 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic [7:0] d, input logic fe, input logic ov);
    exp_t e;
    e.rdy  = r;
    e.data = d;
    e.fe   = fe;
    e.ov   = ov;
    return e;
  endfunction

  // Monitor: every busy->idle transition is a frame outcome to score
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && busy_prev && !rx_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got {rdy,data,fe,ov}=%0h, expected no event",
                   {rdy, data, frame_err, overrun});
        end else begin
          e = exp_q.pop_front();
          chk("frame_outcome {rdy,data,fe,ov}", 32'({rdy, data, frame_err, overrun}), 32'(e));
        end
      end
      busy_prev = rx_busy;
    end
  end

  // Consumer: sole driver of rdy_clr (auto acknowledge, or hold while busy)
  initial begin
    bit ack_pend;
    ack_pend = 1'b0;
    rdy_clr  = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_pend) begin
        chk("rdy_clr clears rdy", 32'(rdy), 32'(0));
        chk("rdy_clr clears overrun", 32'(overrun), 32'(0));
        ack_pend = 1'b0;
        rdy_clr  = 1'b0;
      end else if (hold_clr) begin
        rdy_clr = rx_busy;
      end else if (auto_ack && rdy && !rst) begin
        rdy_clr  = 1'b1;
        ack_pend = 1'b1;
      end else begin
        rdy_clr = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " data"},      32'(data),      32'(0));
    chk({tag, " rdy"},       32'(rdy),       32'(0));
    chk({tag, " frame_err"}, 32'(frame_err), 32'(0));
    chk({tag, " overrun"},   32'(overrun),   32'(0));
    chk({tag, " rx_busy"},   32'(rx_busy),   32'(0));
  endtask

  // One 8N1 frame; optional one-cycle reset mid-slot and rdy_clr hold in stop bit
  task automatic send(input logic [7:0] b, input logic stop_bit, input int rst_slot, input bit hold);
    logic bitv;
    for (int slot = 0; slot < 10; slot++) begin
      if (slot == 0)      bitv = 1'b0;
      else if (slot == 9) bitv = stop_bit;
      else                bitv = b[3'(slot - 1)];
      rx = bitv;
      if (hold && slot == 9) hold_clr = 1'b1;
      for (int c = 0; c < CLKS_PER_BIT; c++) begin
        @(negedge clk);
        if (slot == rst_slot && c == CLKS_PER_BIT / 2) begin
          rst = 1'b1;
        end else if (slot == rst_slot && c == CLKS_PER_BIT / 2 + 1) begin
          rst = 1'b0;
          chk_reset_outputs("mid-frame reset");
        end
      end
    end
    hold_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b1;
    auto_ack = 1'b1;
    hold_clr = 1'b0;
    rst      = 1'b1;
    rx       = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after reset");
    idle(100);

    // 1: basic byte, latency to rdy about 9.5 bit periods
    exp_q.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0));
    lat = 0;
    fork
      send(8'hA5, 1'b1, NO_RST, 1'b0);
      begin
        while (!rdy && lat < 6000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("latency in window", 32'(lat >= 4095 && lat <= 4150), 32'(1));
    idle(300);

    // 2: back-to-back bytes, each acknowledged
    exp_q.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'h81, 1'b0, 1'b0));
    send(8'h00, 1'b1, NO_RST, 1'b0);
    send(8'hFF, 1'b1, NO_RST, 1'b0);
    send(8'h55, 1'b1, NO_RST, 1'b0);
    send(8'h81, 1'b1, NO_RST, 1'b0);
    idle(300);

    // 3: short low pulse is rejected, outputs untouched
    exp_q.push_back(mk(1'b0, 8'h81, 1'b0, 1'b0));
    rx = 1'b0;
    repeat (5 * CLKS_PER_TICK) @(negedge clk);
    idle(400);
    exp_q.push_back(mk(1'b1, 8'h3C, 1'b0, 1'b0));
    send(8'h3C, 1'b1, NO_RST, 1'b0);
    idle(300);

    // 4: low stop bit; the remaining low half-bit also looks like a short start
    exp_q.push_back(mk(1'b0, 8'h3C, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b0, 8'h3C, 1'b1, 1'b0));
    send(8'h12, 1'b0, NO_RST, 1'b0);
    idle(400);
    exp_q.push_back(mk(1'b1, 8'h34, 1'b0, 1'b0));
    send(8'h34, 1'b1, NO_RST, 1'b0);
    idle(300);

    // 5: overrun, then acknowledge held across the completing stop bit
    auto_ack = 1'b0;
    exp_q.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'h22, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0));
    send(8'h11, 1'b1, NO_RST, 1'b0);
    send(8'h22, 1'b1, NO_RST, 1'b0);
    send(8'h33, 1'b1, NO_RST, 1'b1);
    auto_ack = 1'b1;
    idle(300);

    // 6: reset during data bit 4 of 0xF0; the tail must not produce a byte
    mon_en = 1'b0;
    send(8'hF0, 1'b1, 5, 1'b0);
    idle(300);
    chk("aborted frame rx_busy", 32'(rx_busy), 32'(0));
    chk("aborted frame rdy", 32'(rdy), 32'(0));
    mon_en = 1'b1;
    exp_q.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b0));
    send(8'h0F, 1'b1, NO_RST, 1'b0);
    idle(500);

    chk("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
